// File: rtl/uns_gen_if.sv
// Count-to-thermometer LED bus: a load strobe with a requested count in,
// and the LED pattern with its status flags out.
interface uns_gen_if;
    logic [3:0] SW;
    logic       LOAD;
    logic [9:0] LEDR;
    logic [3:0] CUR;
    logic       BUSY;
    logic       DONE;

    modport master (output SW, output LOAD, input LEDR, input CUR, input BUSY, input DONE);
    modport slave  (input SW, input LOAD, output LEDR, output CUR, output BUSY, output DONE);
endinterface

// File: rtl/uns_gen.sv
// Inverse ones-counter: walks a 10-LED thermometer one LED per TICK_DIV cycles
// toward a loaded count (clamped to 10), pulsing DONE on arrival.
module uns_gen #(
    parameter int unsigned TICK_DIV = 5000000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       RESET,
    uns_gen_if.slave   bus
);
    localparam int unsigned PW      = $clog2(TICK_DIV);
    localparam int unsigned CW      = 4;
    localparam int unsigned NLED    = 10;
    localparam logic [CW-1:0] MAXC  = CW'(NLED);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   target, target_nxt;
    logic [CW-1:0]   cur, cur_nxt;
    logic [PW-1:0]   presc, presc_nxt;
    logic [NLED-1:0] ledr, ledr_nxt;
    logic            busy, done;
    logic [CW-1:0]   stepped;

    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
        if (RESET) begin
            state  <= S_IDLE;
            target <= '0;
            cur    <= '0;
            presc  <= '0;
            ledr   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            target <= target_nxt;
            cur    <= cur_nxt;
            presc  <= presc_nxt;
            ledr   <= ledr_nxt;
            busy   <= (state_nxt == S_STEP);
            done   <= (state_nxt == S_DONE);
        end
    end

    // Stepping compares against the registered target, so a new load steers from the next tick.
    always_comb begin
        state_nxt  = state;
        target_nxt = bus.LOAD ? ((bus.SW > MAXC) ? MAXC : bus.SW) : target;
        cur_nxt    = cur;
        presc_nxt  = presc;
        stepped    = (cur < target) ? cur + CW'(1) : cur - CW'(1);
        ledr_nxt   = '0;
        case (state)
            S_IDLE: begin
                if (target != cur) begin
                    state_nxt = S_STEP;
                    presc_nxt = '0;
                end
            end
            S_STEP: begin
                if (target == cur) begin
                    state_nxt = S_DONE;
                end else if (presc == PLAST) begin
                    presc_nxt = '0;
                    cur_nxt   = stepped;
                    if (stepped == target) state_nxt = S_DONE;
                end else begin
                    presc_nxt = presc + PW'(1);
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        for (int i = 0; i < int'(NLED); i++) ledr_nxt[i] = (CW'(i) < cur_nxt);
    end

    assign bus.LEDR = ledr;
    assign bus.CUR  = cur;
    assign bus.BUSY = busy;
    assign bus.DONE = done;
endmodule

// File: tb/tb_uns_gen.sv
// Randomized and directed bench for uns_gen (TICK_DIV=4) against a
// cycle-level behavioural model of the LED stepping rules.
module tb_uns_gen;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uns_gen_if bus_if ();

    uns_gen #(.TICK_DIV(TD)) dut (
        .MAX10_CLK1_50 (clk),
        .RESET         (rst),
        .bus           (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Model: phase 0 idle, 1 stepping, 2 arrived; cnt = cycles spent in the current move.
    int m_cur, m_tgt, m_phase, m_cnt;
    int n_done, n_busy;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = 0; m_tgt = 0; m_phase = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit ld, input int sw);
        int nt;
        nt = ld ? ((sw > 10) ? 10 : sw) : m_tgt;
        case (m_phase)
            0: if (m_tgt != m_cur) begin m_phase = 1; m_cnt = 0; end
            1: begin
                if (m_tgt == m_cur) m_phase = 2;
                else begin
                    m_cnt++;
                    if (m_cnt % TD == 0) begin
                        m_cur = m_cur + ((m_tgt > m_cur) ? 1 : -1);
                        if (m_cur == m_tgt) m_phase = 2;
                    end
                end
            end
            default: m_phase = 0;
        endcase
        m_tgt = nt;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".cur"},  int'(bus_if.CUR),  m_cur);
        chk({tag, ".ledr"}, int'(bus_if.LEDR), (1 << m_cur) - 1);
        chk({tag, ".busy"}, int'(bus_if.BUSY), (m_phase == 1) ? 1 : 0);
        chk({tag, ".done"}, int'(bus_if.DONE), (m_phase == 2) ? 1 : 0);
    endtask

    task automatic tick(input bit ld, input int sw, input string tag);
        @(negedge clk);
        bus_if.LOAD = ld;
        bus_if.SW   = 4'(sw);
        @(posedge clk);
        model_edge(ld, sw);
        #1;
        chk_outputs(tag);
        if (bus_if.DONE) n_done++;
        if (bus_if.BUSY) n_busy++;
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 0, tag);
    endtask

    task automatic clr_counts();
        n_done = 0; n_busy = 0;
    endtask

    initial begin
        bus_if.SW = '0; bus_if.LOAD = 1'b0;
        model_reset(); clr_counts();

        // Reset, with a LOAD presented during reset that must be ignored.
        rst = 1'b1;
        #2;
        chk_outputs("reset");
        @(negedge clk); bus_if.LOAD = 1'b1; bus_if.SW = 4'd7;
        @(posedge clk); #1;
        chk_outputs("reset_load");
        @(negedge clk); rst = 1'b0; bus_if.LOAD = 1'b0;
        run(6, "post_reset");

        // 0 -> 3
        clr_counts();
        tick(1'b1, 3, "up3");
        run(1, "up3");
        chk("up3.busy_latency", int'(bus_if.BUSY), 1);
        run(16, "up3");
        chk("up3.final", int'(bus_if.CUR), 3);
        chk("up3.ndone", n_done, 1);
        chk("up3.nbusy", n_busy, 12);

        // 3 -> 15 clamps to 10
        clr_counts();
        tick(1'b1, 15, "clamp");
        run(40, "clamp");
        chk("clamp.cur", int'(bus_if.CUR), 10);
        chk("clamp.ledr", int'(bus_if.LEDR), 32'h3FF);
        chk("clamp.ndone", n_done, 1);

        // 10 -> 0 takes 40 cycles in STEP
        clr_counts();
        tick(1'b1, 0, "down0");
        run(45, "down0");
        chk("down0.nbusy", n_busy, 40);
        chk("down0.ledr", int'(bus_if.LEDR), 0);
        chk("down0.ndone", n_done, 1);

        // 0 -> 8, reverse to 2 at CUR=4 mid-prescale
        clr_counts();
        tick(1'b1, 8, "rev");
        run(17, "rev");
        chk("rev.at4", int'(bus_if.CUR), 4);
        run(2, "rev");
        tick(1'b1, 2, "rev");
        run(2, "rev");
        chk("rev.first_back", int'(bus_if.CUR), 3);
        run(12, "rev");
        chk("rev.final", int'(bus_if.CUR), 2);
        chk("rev.ndone", n_done, 1);

        // LOAD equal to CUR in IDLE: nothing happens
        clr_counts();
        tick(1'b1, 2, "same_idle");
        run(6, "same_idle");
        chk("same_idle.nbusy", n_busy, 0);
        chk("same_idle.ndone", n_done, 0);

        // LOAD equal to CUR during STEP: DONE next edge, CUR unchanged
        clr_counts();
        tick(1'b1, 6, "same_step");
        run(5, "same_step");
        tick(1'b1, 3, "same_step");
        run(1, "same_step");
        chk("same_step.done", int'(bus_if.DONE), 1);
        chk("same_step.cur", int'(bus_if.CUR), 3);
        run(4, "same_step");
        chk("same_step.ndone", n_done, 1);

        // Async reset mid-STEP at CUR=5
        tick(1'b1, 9, "areset");
        run(9, "areset");
        chk("areset.at5", int'(bus_if.CUR), 5);
        run(1, "areset");
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("areset.async");
        @(negedge clk); rst = 1'b0;
        clr_counts();
        run(10, "areset.idle");
        chk("areset.nbusy", n_busy, 0);

        // Random loads
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 11) == 0) tick(1'b1, int'($urandom_range(0, 15)), "rand");
            else tick(1'b0, int'($urandom_range(0, 15)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
